// File: rtl/instr_mem_loader.sv
// instr_mem_loader: byte-addressed instruction memory with registered fetch and streaming byte loader
module instr_mem_loader #(
    parameter int          ADDR_W      = 9,
    parameter bit          ALIGN_CHECK = 1'b1,
    parameter logic [31:0] FAULT_INSTR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [31:0]       fetch_pc,
    output logic              fetch_ready,
    output logic              instr_valid,
    output logic [31:0]       instr,
    output logic              instr_fault,
    output logic [1:0]        fault_code,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_base,
    input  logic              load_valid,
    input  logic [7:0]        load_byte,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_done,
    output logic              load_overflow
);
    localparam int          DEPTH   = 2 ** ADDR_W;
    localparam logic [31:0] LAST_PC = 32'(DEPTH - 4);

    typedef enum logic {IDLE, LOAD} state_t;

    state_t            state;
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W:0]   cnt;
    logic [ADDR_W-1:0] a0, a1, a2, a3;
    logic              accept, misaligned, out_of_range, faulted, wr_en;

    assign fetch_ready  = (state == IDLE) && !load_start;
    assign accept       = fetch_req && fetch_ready;
    assign misaligned   = ALIGN_CHECK && (fetch_pc[1:0] != 2'b00);
    assign out_of_range = fetch_pc > LAST_PC;
    assign faulted      = misaligned || out_of_range;
    assign wr_en        = (state == LOAD) && load_valid && !cnt[ADDR_W];
    assign a0           = fetch_pc[ADDR_W-1:0];
    assign a1           = a0 + ADDR_W'(1);
    assign a2           = a0 + ADDR_W'(2);
    assign a3           = a0 + ADDR_W'(3);

    // byte store; the counter's top bit marks the address past DEPTH-1
    always_ff @(posedge clk)
        if (wr_en) mem[cnt[ADDR_W-1:0]] <= load_byte;

    // registered fetch: faults take priority and suppress the memory read
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_fault <= 1'b0;
            fault_code  <= 2'b00;
        end else begin
            instr_valid <= accept;
            if (accept) begin
                instr_fault <= faulted;
                fault_code  <= misaligned ? 2'b01 : out_of_range ? 2'b10 : 2'b00;
                instr       <= faulted ? FAULT_INSTR : {mem[a0], mem[a1], mem[a2], mem[a3]};
            end
        end

    // load session control with registered handshake outputs
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state         <= IDLE;
            cnt           <= '0;
            load_ready    <= 1'b0;
            load_done     <= 1'b0;
            load_overflow <= 1'b0;
        end else begin
            load_done <= 1'b0;
            case (state)
                IDLE: if (load_start) begin
                    state         <= LOAD;
                    cnt           <= {1'b0, load_base};
                    load_ready    <= 1'b1;
                    load_overflow <= 1'b0;
                end
                LOAD: if (load_valid) begin
                    if (!cnt[ADDR_W]) cnt <= cnt + (ADDR_W+1)'(1);
                    else load_overflow <= 1'b1;
                    if (load_last) begin
                        state      <= IDLE;
                        load_ready <= 1'b0;
                        load_done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: scoreboard bench for instr_mem_loader with directed vectors
module tb_instr_mem_loader;
    localparam int ADDR_W = 9;

    logic              clk = 1'b0, rst = 1'b0;
    logic              fetch_req = 1'b0, load_start = 1'b0, load_valid = 1'b0, load_last = 1'b0;
    logic [31:0]       fetch_pc = '0;
    logic [ADDR_W-1:0] load_base = '0;
    logic [7:0]        load_byte = '0;
    logic              fetch_ready, instr_valid, instr_fault, load_ready, load_done, load_overflow;
    logic [31:0]       instr;
    logic [1:0]        fault_code;

    typedef struct {
        int          cyc;
        logic [31:0] instr;
        logic        fault;
        logic [1:0]  code;
    } exp_t;

    exp_t q[$];
    int   tests = 0, fails = 0, cyc = 0, done_cnt = 0;

    instr_mem_loader #(.ADDR_W(ADDR_W), .ALIGN_CHECK(1'b1), .FAULT_INSTR(32'h0)) dut (
        .clk(clk), .rst(rst),
        .fetch_req(fetch_req), .fetch_pc(fetch_pc), .fetch_ready(fetch_ready),
        .instr_valid(instr_valid), .instr(instr), .instr_fault(instr_fault), .fault_code(fault_code),
        .load_start(load_start), .load_base(load_base), .load_valid(load_valid),
        .load_byte(load_byte), .load_last(load_last), .load_ready(load_ready),
        .load_done(load_done), .load_overflow(load_overflow)
    );

    always #5 clk = ~clk;

    // cycle index used to pin each expected response to its cycle
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: every cycle valid must match whether a response is due, then fields are compared
    always @(negedge clk)
        if (rst) begin : mon
            exp_t e;
            logic due;
            if (load_done) done_cnt++;
            due = (q.size() > 0) && (q[0].cyc <= cyc);
            chk("instr_valid", 32'(instr_valid), 32'(due));
            if (due) begin
                e = q.pop_front();
                if (instr_valid) begin
                    chk("instr", instr, e.instr);
                    chk("instr_fault", 32'(instr_fault), 32'(e.fault));
                    chk("fault_code", 32'(fault_code), 32'(e.code));
                end
            end
        end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] pc, input logic [31:0] ei, input logic ef, input logic [1:0] ec);
        exp_t e;
        step();
        fetch_req = 1'b1;
        fetch_pc  = pc;
        e = '{cyc + 1, ei, ef, ec};
        q.push_back(e);
    endtask

    task automatic fetch_idle();
        step();
        fetch_req = 1'b0;
        repeat (3) step();
    endtask

    task automatic load(input logic [ADDR_W-1:0] base, input logic [7:0] b[$]);
        step();
        load_start = 1'b1;
        load_base  = base;
        step();
        load_start = 1'b0;
        chk("load_ready_in_load", 32'(load_ready), 32'd1);
        foreach (b[i]) begin
            load_valid = 1'b1;
            load_byte  = b[i];
            load_last  = (i == b.size() - 1);
            step();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        repeat (2) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0]  b[$];
        logic [31:0] w;
        int          d;
        #2;
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_fault", 32'(instr_fault), 32'd0);
        chk("rst_fault_code", 32'(fault_code), 32'd0);
        chk("rst_load_ready", 32'(load_ready), 32'd0);
        chk("rst_load_done", 32'(load_done), 32'd0);
        chk("rst_load_overflow", 32'(load_overflow), 32'd0);
        chk("rst_fetch_ready", 32'(fetch_ready), 32'd1);
        #10 rst = 1'b1;

        // program: word i = 0x24020001 + i, big-endian, 128 bytes from base 0
        for (int i = 0; i < 32; i++) begin
            w = 32'h2402_0001 + 32'(i);
            b.push_back(w[31:24]);
            b.push_back(w[23:16]);
            b.push_back(w[15:8]);
            b.push_back(w[7:0]);
        end
        d = done_cnt;
        load(9'h000, b);
        chk("load_done_pulses_prog", 32'(done_cnt - d), 32'd1);
        chk("no_overflow_prog", 32'(load_overflow), 32'd0);

        fetch(32'h10, 32'h2402_0005, 1'b0, 2'b00);
        fetch(32'h00, 32'h2402_0001, 1'b0, 2'b00);
        fetch(32'h04, 32'h2402_0002, 1'b0, 2'b00);
        fetch(32'h08, 32'h2402_0003, 1'b0, 2'b00);
        fetch(32'h06, 32'h0, 1'b1, 2'b01);
        fetch(32'h1FE, 32'h0, 1'b1, 2'b01);
        fetch(32'h200, 32'h0, 1'b1, 2'b10);
        fetch(32'h1000, 32'h0, 1'b1, 2'b10);
        fetch(32'h8000_0000, 32'h0, 1'b1, 2'b10);
        fetch_idle();

        // fill 0x1FC..0x1FD, then overflow past the top
        b = {};
        b.push_back(8'h11);
        b.push_back(8'h22);
        d = done_cnt;
        load(9'h1FC, b);
        b = {};
        b.push_back(8'hAA);
        b.push_back(8'hBB);
        b.push_back(8'hCC);
        b.push_back(8'hDD);
        load(9'h1FE, b);
        chk("load_done_pulses_top", 32'(done_cnt - d), 32'd2);
        chk("overflow_set", 32'(load_overflow), 32'd1);
        fetch(32'h1FC, 32'h1122_AABB, 1'b0, 2'b00);
        fetch_idle();

        // load_start and fetch_req together: load wins, then reset mid-load
        d = done_cnt;
        step();
        load_start = 1'b1;
        load_base  = 9'h040;
        fetch_req  = 1'b1;
        fetch_pc   = 32'h0;
        #1 chk("fetch_ready_on_load_start", 32'(fetch_ready), 32'd0);
        step();
        load_start = 1'b0;
        fetch_req  = 1'b0;
        chk("overflow_cleared_by_start", 32'(load_overflow), 32'd0);
        b = {};
        b.push_back(8'h5A);
        b.push_back(8'h6B);
        b.push_back(8'h7C);
        b.push_back(8'h8D);
        foreach (b[i]) begin
            load_valid = 1'b1;
            load_byte  = b[i];
            step();
        end
        load_byte = 8'h9E;
        #2 rst = 1'b0;
        load_valid = 1'b0;
        #1;
        chk("midload_rst_load_ready", 32'(load_ready), 32'd0);
        chk("midload_rst_fetch_ready", 32'(fetch_ready), 32'd1);
        chk("midload_rst_load_done", 32'(load_done), 32'd0);
        #2 rst = 1'b1;
        fetch(32'h40, 32'h5A6B_7C8D, 1'b0, 2'b00);
        fetch(32'h44, 32'h2402_0012, 1'b0, 2'b00);
        fetch_idle();
        chk("no_done_after_rst", 32'(done_cnt - d), 32'd0);
        chk("scoreboard_drained", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
